// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared handshake FSM state type and default constants for the cdc_hs transmitter/receiver pair.
package cdc_hs_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DROP} hs_state_e;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: multi-flop single-bit synchronizer with synchronous clear.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff_q;
  always_ff @(posedge clk) ff_q <= rst ? '0 : {ff_q[STAGES-2:0], d};
  assign q = ff_q[STAGES-1];
endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: four-phase req/ack transmitter holding one word across a clock-domain crossing.
// Optional sticky ack-timeout flag enabled by defining CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_vld,
  input  logic [DW-1:0] up_data,
  output logic          up_rdy,
  output logic          tx_req,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ack,
  output logic          done,
  output logic          err
);
  hs_state_e     state_q, state_d;
  logic          req_q, req_d, done_q, done_d, low_q, low_d, ack_s;
  logic [DW-1:0] data_q, data_d;
  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(tx_ack), .q(ack_s));
  // low_q records that ack_s has been seen low since acceptance, so a stale ack cannot end REQ
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    low_d   = low_q;
    done_d  = 1'b0;
    if (up_vld && up_rdy) begin
      state_d = REQ;
      req_d   = 1'b1;
      data_d  = up_data;
      low_d   = ~ack_s;
    end else if (state_q == REQ && ack_s && low_q) begin
      state_d = DROP;
      req_d   = 1'b0;
    end else if (state_q == REQ && !ack_s) begin
      low_d = 1'b1;
    end else if (state_q == DROP && !ack_s) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      low_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      low_q   <= low_d;
      done_q  <= done_d;
    end
  end
  assign up_rdy  = state_q == IDLE && !done_q;
  assign tx_req  = req_q;
  assign tx_data = data_q;
  assign done    = done_q;
`ifdef CDC_HS_TX_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  always_comb begin
    cnt_d = state_q == IDLE ? '0 : (cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1);
    err_d = err_q || (state_q != IDLE && {16'd0, cnt_q} + 32'd1 == TIMEOUT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: vector table plus corner-case sequences with a tx_data scoreboard for cdc_hs_tx.
module tb_cdc_hs_tx;
  localparam int SYNC = 2;
  localparam int LAT  = 2 * SYNC + 3;
`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b1, up_vld = 1'b0, ack_follow = 1'b1, ack_force = 1'b0;
  logic [7:0] up_data = '0, tx_data;
  logic       up_rdy, tx_req, tx_ack, done, err, req_prev = 1'b0;
  int         tests = 0, fails = 0;
  logic [7:0] sb[$];
  assign tx_ack = ack_follow ? tx_req : ack_force;
  cdc_hs_tx #(.DW(8), .SYNC_STAGES(SYNC), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_data(up_data), .up_rdy(up_rdy),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // each new request must carry the oldest word pushed at acceptance time
  always @(negedge clk) begin
    if (tx_req && !req_prev) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %0h expected none", tx_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL sb_data: got %0h expected %0h", tx_data, e);
        end
      end
    end
    req_prev <= tx_req;
  end
  task automatic wait_done(output int lat, output int rdy_hi);
    lat = 1;
    rdy_hi = 0;
    while (!done && lat < 60) begin
      rdy_hi += up_rdy ? 1 : 0;
      tick();
      lat++;
    end
  endtask
  task automatic xfer(input logic [7:0] d, output int lat, output int rdy_hi);
    check("xfer_rdy", up_rdy, 1);
    up_vld = 1'b1;
    up_data = d;
    sb.push_back(d);
    tick();
    up_vld = 1'b0;
    up_data = 8'hEE;
    wait_done(lat, rdy_hi);
  endtask
  typedef struct {logic [7:0] data; int lat;} vec_t;
  vec_t vecs[4];
  initial begin
    int lat, hi, fell;
    vecs[0] = '{8'hA5, LAT};
    vecs[1] = '{8'h00, LAT};
    vecs[2] = '{8'hFF, LAT};
    vecs[3] = '{8'h3C, LAT};
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rdy", up_rdy, 1);
    check("rst_req", tx_req, 0);
    check("rst_data", tx_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    foreach (vecs[i]) begin
      xfer(vecs[i].data, lat, hi);
      check("vec_lat", lat, vecs[i].lat);
      check("vec_rdy_low", hi, 0);
      check("vec_data_held", tx_data, vecs[i].data);
      tick();
      check("vec_done_pulse", done, 0);
    end
    up_vld = 1'b1;
    up_data = 8'h11;
    sb.push_back(8'h11);
    tick();
    up_data = 8'h22;
    wait_done(lat, hi);
    check("busy_lat", lat, LAT);
    check("busy_rdy_low", hi, 0);
    check("busy_done_rdy", up_rdy, 0);
    tick();
    check("busy_no_b2b", tx_req, 0);
    check("busy_rdy_after", up_rdy, 1);
    sb.push_back(8'h22);
    tick();
    up_vld = 1'b0;
    check("busy_second", tx_data, 8'h22);
    wait_done(lat, hi);
    check("busy2_lat", lat, LAT);
    tick();
    ack_follow = 1'b0;
    ack_force = 1'b1;
    repeat (4) tick();
    up_vld = 1'b1;
    up_data = 8'h5A;
    sb.push_back(8'h5A);
    tick();
    up_vld = 1'b0;
    fell = 0;
    repeat (4) begin tick(); fell += tx_req ? 0 : 1; end
    ack_force = 1'b0;
    repeat (5) begin tick(); fell += tx_req ? 0 : 1; end
    check("stale_held", fell, 0);
    ack_force = 1'b1;
    lat = 0;
    while (tx_req && lat < 20) begin tick(); lat++; end
    check("stale_fall", lat, SYNC + 1);
    ack_force = 1'b0;
    wait_done(lat, hi);
    check("stale_done", done, 1);
    tick();
    up_vld = 1'b1;
    up_data = 8'h77;
    sb.push_back(8'h77);
    tick();
    up_vld = 1'b0;
    tick();
    check("mid_in_req", tx_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_req", tx_req, 0);
    check("mid_rdy", up_rdy, 1);
    check("mid_err", err, 0);
    hi = 0;
    repeat (10) begin hi += done ? 1 : 0; tick(); end
    check("mid_no_done", hi, 0);
    up_vld = 1'b1;
    up_data = 8'h33;
    sb.push_back(8'h33);
    tick();
    up_vld = 1'b0;
    repeat (9) tick();
    check("to_before", err, 0);
    tick();
    check("to_set", err, TO_EN);
    repeat (5) tick();
    check("to_sticky", err, TO_EN);
    check("to_still_req", tx_req, 1);
    ack_follow = 1'b1;
    wait_done(lat, hi);
    check("to_done", done, 1);
    tick();
    check("to_sticky_idle", err, TO_EN);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("to_rst_clear", err, 0);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
